clock_enable_gen: RTL and testbench

- Parametrised multi-channel timebase generator; successor to the single fixed 1 Hz divider.
- Produces NUM_CH independent outputs from the 100 MHz system clock:
  - a one-cycle clock-enable pulse (tick);
  - a 50%-duty square wave (sq) for display blink and buzzer.
- Each divisor is runtime-programmable. Downstream timekeeping/alarm logic runs on clk, gated by tick; no derived clocks.

---
 rtl/clkgen_pkg.sv | 23 ++
 rtl/clkgen_channel.sv | 77 +++++++
 rtl/clock_enable_gen.sv | 65 ++++++
 tb/tb_clock_enable_gen.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/clkgen_pkg.sv
// rtl/clkgen_pkg.sv - shared constants, counter type and clog2 helper for clock_enable_gen
package clkgen_pkg;

    localparam int CLK_HZ       = 100_000_000;
    localparam int DEFAULT_DIV  = CLK_HZ;
    localparam int HALF_SEC_DIV = 50_000_000;
    localparam int DEF_CNT_W    = 28;

    typedef logic [DEF_CNT_W-1:0] cnt_t;

    function automatic int clog2(input int value);
        int result;
        int rem;
        result = 0;
        rem    = value - 1;
        while (rem > 0) begin
            result = result + 1;
            rem    = rem >> 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/clkgen_channel.sv
// rtl/clkgen_channel.sv - one timebase channel: shadow/active divisor, counter, tick and square wave
// CLKEN_CASCADE_EN exposes the combinational wrap strobe used to chain channels.
module clkgen_channel
    import clkgen_pkg::*;
#(
    parameter int               CNT_W   = DEF_CNT_W,
    parameter logic [CNT_W-1:0] RST_DIV = '1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             advance,
    input  logic             clr,
    input  logic             we,
    input  logic [CNT_W-1:0] wdata,
    output logic             tick,
    output logic             sq
`ifdef CLKEN_CASCADE_EN
    ,
    output logic             wrap
`endif
);

    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] sdiv;
    logic [CNT_W-1:0] adiv;
    logic [CNT_W-1:0] d;
    logic [CNT_W-1:0] half;
    logic [CNT_W-1:0] cnt_inc;
    logic             last;

    // A zero divisor behaves like one: tick every enabled cycle.
    assign d       = (adiv == '0) ? CNT_W'(1) : adiv;
    assign half    = d >> 1;
    assign cnt_inc = cnt + CNT_W'(1);
    assign last    = (cnt == d - CNT_W'(1));

`ifdef CLKEN_CASCADE_EN
    assign wrap = advance & ~clr & last;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt  <= '0;
            tick <= 1'b0;
            sq   <= 1'b0;
            sdiv <= RST_DIV;
            adiv <= RST_DIV;
        end else begin
            if (we) begin
                sdiv <= wdata;
            end
            // adiv reloads from the pre-edge sdiv, so a colliding write lands one period later.
            if (clr) begin
                cnt  <= '0;
                tick <= 1'b0;
                sq   <= 1'b0;
                adiv <= sdiv;
            end else if (advance) begin
                if (last) begin
                    cnt  <= '0;
                    tick <= 1'b1;
                    sq   <= 1'b0;
                    adiv <= sdiv;
                end else begin
                    cnt  <= cnt_inc;
                    tick <= 1'b0;
                    if (d >= CNT_W'(2) && cnt_inc == half) begin
                        sq <= 1'b1;
                    end
                end
            end else begin
                tick <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/clock_enable_gen.sv
// rtl/clock_enable_gen.sv - multi-channel clock-enable and square-wave timebase (top)
// CLKEN_CASCADE_EN: channel k>=1 advances only when channel k-1 wraps.
module clock_enable_gen
    import clkgen_pkg::*;
#(
    parameter int  NUM_CH      = 3,
    parameter int  CNT_W       = DEF_CNT_W,
    parameter int  DEFAULT_DIV = clkgen_pkg::DEFAULT_DIV,
    localparam int CH_W        = (NUM_CH > 1) ? clog2(NUM_CH) : 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              en,
    input  logic              sync_clr,
    input  logic              cfg_we,
    input  logic [CH_W-1:0]   cfg_ch,
    input  logic [CNT_W-1:0]  cfg_div,
    output logic [NUM_CH-1:0] tick,
    output logic [NUM_CH-1:0] sq
);

    localparam logic [CNT_W-1:0] RST_DIV = CNT_W'(DEFAULT_DIV);

    logic [NUM_CH-1:0] we_ch;
    logic [NUM_CH-1:0] adv;
`ifdef CLKEN_CASCADE_EN
    logic [NUM_CH-1:0] wrap;
`endif

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        localparam logic [CH_W-1:0] IDX = CH_W'(i);

        // Out-of-range channel numbers match no index and are dropped.
        assign we_ch[i] = cfg_we & (cfg_ch == IDX);

`ifdef CLKEN_CASCADE_EN
        if (i == 0) begin : g_root
            assign adv[i] = en;
        end else begin : g_child
            assign adv[i] = wrap[i-1];
        end
`else
        assign adv[i] = en;
`endif

        clkgen_channel #(
            .CNT_W   (CNT_W),
            .RST_DIV (RST_DIV)
        ) u_channel (
            .clk     (clk),
            .reset   (reset),
            .advance (adv[i]),
            .clr     (sync_clr),
            .we      (we_ch[i]),
            .wdata   (cfg_div),
            .tick    (tick[i]),
            .sq      (sq[i])
`ifdef CLKEN_CASCADE_EN
            ,
            .wrap    (wrap[i])
`endif
        );
    end

endmodule

// File: tb/tb_clock_enable_gen.sv
// tb/tb_clock_enable_gen.sv - randomized self-checking bench for clock_enable_gen against a period model
module tb_clock_enable_gen;

    localparam int NCH = 3;

    logic       clk;
    logic       reset;
    logic       en;
    logic       sync_clr;
    logic       cfg_we;
    logic [1:0] cfg_ch;
    logic [7:0] cfg_div;
    logic [2:0] tick;
    logic [2:0] sq;

    int checks;
    int failures;

    int         shadow [NCH];
    int         active [NCH];
    int         elapsed[NCH];
    logic [2:0] exp_tick;
    logic [2:0] exp_sq;

    clock_enable_gen #(
        .NUM_CH      (3),
        .CNT_W       (8),
        .DEFAULT_DIV (10)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .en       (en),
        .sync_clr (sync_clr),
        .cfg_we   (cfg_we),
        .cfg_ch   (cfg_ch),
        .cfg_div  (cfg_div),
        .tick     (tick),
        .sq       (sq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < NCH; k++) begin
            shadow[k]  = 10;
            active[k]  = 10;
            elapsed[k] = 0;
        end
        exp_tick = '0;
        exp_sq   = '0;
    endtask

    // Each period lasts d enabled cycles; the tick marks its completion and
    // sq is high for the second part of it (elapsed >= d/2).
    task automatic model_step(input logic e, input logic c, input logic w,
                              input int ch, input int dv);
        bit wrapped[NCH];
        bit step_k;
        int d;
        for (int k = 0; k < NCH; k++) begin
            d = (active[k] == 0) ? 1 : active[k];
            step_k = e;
`ifdef CLKEN_CASCADE_EN
            if (k > 0) step_k = wrapped[k-1];
`endif
            wrapped[k] = 1'b0;
            if (c) begin
                elapsed[k]  = 0;
                exp_tick[k] = 1'b0;
                exp_sq[k]   = 1'b0;
                active[k]   = shadow[k];
            end else if (step_k) begin
                elapsed[k] = elapsed[k] + 1;
                if (elapsed[k] == d) begin
                    elapsed[k]  = 0;
                    exp_tick[k] = 1'b1;
                    exp_sq[k]   = 1'b0;
                    active[k]   = shadow[k];
                    wrapped[k]  = 1'b1;
                end else begin
                    exp_tick[k] = 1'b0;
                    exp_sq[k]   = (d >= 2) && (elapsed[k] >= d / 2);
                end
            end else begin
                exp_tick[k] = 1'b0;
            end
        end
        if (w && ch < NCH) shadow[ch] = dv;
    endtask

    task automatic cycle(input logic e, input logic c, input logic w,
                         input int ch, input int dv);
        @(negedge clk);
        check("tick", 32'(tick), 32'(exp_tick));
        check("sq", 32'(sq), 32'(exp_sq));
        en       = e;
        sync_clr = c;
        cfg_we   = w;
        cfg_ch   = 2'(ch);
        cfg_div  = 8'(dv);
        model_step(e, c, w, ch, dv);
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cycle(1'b1, 1'b0, 1'b0, 0, 0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset    = 1'b1;
        en       = 1'b0;
        sync_clr = 1'b0;
        cfg_we   = 1'b0;
        model_reset();
        #1;
        check("rst_tick", 32'(tick), 32'(0));
        check("rst_sq", 32'(sq), 32'(0));
        @(negedge clk);
        reset = 1'b0;
        model_step(1'b0, 1'b0, 1'b0, 0, 0);
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        reset    = 1'b1;
        en       = 1'b0;
        sync_clr = 1'b0;
        cfg_we   = 1'b0;
        cfg_ch   = '0;
        cfg_div  = '0;
        model_reset();
        repeat (3) @(negedge clk);
        do_reset();

        // Default divisor 10: all channels tick after the 10th enabled edge.
        run(10);
        @(posedge clk);
        #1;
        check("first_tick_c10", 32'(tick), 32'h7);
        run(25);

        // Divisors 4 and 5 applied through sync_clr.
        cycle(1'b1, 1'b0, 1'b1, 0, 4);
        cycle(1'b1, 1'b0, 1'b1, 1, 5);
        cycle(1'b1, 1'b1, 1'b0, 0, 0);
        run(30);

        // Degenerate divisors on channel 2.
        cycle(1'b1, 1'b0, 1'b1, 2, 1);
        run(20);
        cycle(1'b1, 1'b0, 1'b1, 2, 0);
        run(20);

        // Mid-period divisor change, out-of-range write, en gap.
        cycle(1'b1, 1'b1, 1'b0, 0, 0);
        run(1);
        cycle(1'b1, 1'b0, 1'b1, 0, 6);
        cycle(1'b1, 1'b0, 1'b1, 3, 2);
        run(20);
        run(2);
        repeat (3) cycle(1'b0, 1'b0, 1'b0, 0, 0);
        run(20);

        // Reset mid-period, then restart with the default divisor.
        do_reset();
        run(7);
        do_reset();
        run(25);

        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 999) < 3) begin
                do_reset();
            end else begin
                cycle($urandom_range(0, 99) < 85,
                      $urandom_range(0, 99) < 2,
                      $urandom_range(0, 99) < 8,
                      int'($urandom_range(0, 3)),
                      int'($urandom_range(0, 9)));
            end
        end
        run(2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
